vram_fill_responder: RTL and testbench
======================================

VRAM_FILL_RESPONDER -- requirements
Module: vram_fill_responder

Interface
REQ-001 Parameter VRAM_BASE, default 32'h00010000; byte address of pixel (0,0).
REQ-002 Parameter SCREEN_W, default 320; pixels per row. Parameter SCREEN_H, default 240; rows.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port sel, input, 1: CPU access targets this block (decoded externally).
REQ-006 Port address_a, input, 30: CPU word address; bits [2:0] select the register.
REQ-007 Port data_a, input, 32: CPU write data.
REQ-008 Port byteena_a, input, 4: write lane enables; [3]=bits 31:24 ... [0]=bits 7:0.
REQ-009 Port wren_a, input, 1: CPU write strobe, effective only with sel.
REQ-010 Port q_a, output, 32: registered read data.
REQ-011 Port vram_addr, output, 30: VRAM word address. Port vram_data, output, 32: VRAM write data.
REQ-012 Port vram_byteen, output, 4: VRAM lane enables, same lane order as byteena_a.
REQ-013 Port vram_wren, output, 1: VRAM write request. Port vram_ready, input, 1: write accepted when vram_wren & vram_ready.
REQ-014 Port busy, output, 1: fill in progress. Port irq, output, 1: level interrupt.

Function
REQ-015 Registers by address_a[2:0]: 0 CTRL, 1 X[8:0], 2 Y[7:0], 3 W[8:0], 4 H[7:0], 5 COLOR[7:0], 6 COUNT[16:0] (read-only), 7 reserved (reads 0, writes ignored).
REQ-016 CTRL: bit0 GO (write 1 starts; reads busy); bit1 IRQ_EN (R/W); bit2 DONE (sticky; write 1 clears). Other bits read 0.
REQ-017 Register writes honour byteena_a per lane; unused bits read 0.
REQ-018 q_a updates one clock after a cycle with sel=1, holds otherwise; read latency 1 cycle, read has no side effects.
REQ-019 While busy, writes to X, Y, W, H, COLOR and GO are ignored; IRQ_EN and DONE-clear still take effect.
REQ-020 FSM states IDLE, CLIP, FILL, FIN; busy=1 in every state except IDLE.
REQ-021 IDLE -> CLIP on GO write; the same edge clears DONE and COUNT.
REQ-022 CLIP (1 cycle): if W=0, H=0, X>=SCREEN_W or Y>=SCREEN_H -> FIN with no writes.
REQ-023 CLIP otherwise: effective width = min(W, SCREEN_W-X); effective height = min(H, SCREEN_H-Y); then -> FILL.
REQ-024 FILL: pixel byte address = VRAM_BASE + y*SCREEN_W + x. Each row is covered by consecutive word writes from the first to the last word the span touches.
REQ-025 Each word write: vram_addr = byte address[31:2]; vram_byteen set only for pixels inside the span (pixel at byte offset 0 = lane [3]); vram_data = {4{COLOR}}.
REQ-026 vram_wren asserted continuously in FILL. vram_addr, vram_data and vram_byteen are held stable until the cycle vram_ready=1. The next word or row is presented on the following cycle.
REQ-027 COUNT increments by 1 per accepted write and saturates at 17'h1FFFF.
REQ-028 When the last word of the last row is accepted: FILL -> FIN. FIN (1 cycle) sets DONE and -> IDLE.
REQ-029 First vram_wren occurs 2 cycles after the GO write edge.
REQ-030 irq = DONE & IRQ_EN, registered.
REQ-031 A GO write and a DONE-clear in the same write: DONE cleared, fill starts.

Reset
REQ-032 On reset, at the next clk edge: state IDLE; all registers 0; q_a, vram_addr, vram_data, vram_byteen, vram_wren, busy and irq all 0.
REQ-033 Reset during FILL aborts the fill immediately with no further writes, and DONE stays 0.

Verification
REQ-034 Reset with random bus activity -> all outputs 0, register reads return 0.
REQ-035 X=0,Y=0,W=4,H=1,COLOR=0x5A, ready=1, GO -> exactly one write: addr 0x4000, data 0x5A5A5A5A, byteen 1111; COUNT=1, DONE=1, busy falls.
REQ-036 X=1,Y=0,W=6,H=1 -> two writes: 0x4000 with byteen 0111, then 0x4001 with byteen 1110.
REQ-037 X=318,Y=239,W=10,H=5 -> one write: addr 0x8AFF, byteen 0011; COUNT=1.
REQ-038 Hold vram_ready low for 3 cycles mid-fill -> request held stable; total write count unchanged.
REQ-039 W=0, IRQ_EN=1, GO -> no vram_wren; DONE=1 and irq=1 within 3 cycles. Write CTRL bit2=1 -> irq=0. Reset mid-fill -> vram_wren=0 next cycle.

Source files
------------

// File: rtl/vram_fill_responder.sv
// vram_fill_responder
//   Memory-mapped rectangle fill engine. The CPU programs X/Y/W/H/COLOR and
//   writes GO. The block clips the rectangle to the screen and emits one
//   VRAM word write per 32-bit word touched on each row (8 bpp, 4 pixels per
//   word, pixel at byte offset 0 in lane 3). It then raises DONE and,
//   optionally, a level interrupt.
//
// Ports
//   clk, reset      : single clock, synchronous active-high reset
//   sel, wren_a     : CPU access strobe / write strobe (write needs sel)
//   address_a[2:0]  : register select (upper bits ignored)
//   data_a          : CPU write data
//   byteena_a       : per-lane write enables
//   q_a             : registered read data (one cycle after a sel cycle)
//   vram_addr       : VRAM word address
//   vram_data       : VRAM write data
//   vram_byteen     : VRAM lane enables
//   vram_wren       : VRAM write request
//   vram_ready      : write accepted when vram_wren & vram_ready
//   busy            : fill engine not idle
//   irq             : DONE & IRQ_EN
`timescale 1ns/1ps
module vram_fill_responder #(
    parameter logic [31:0] VRAM_BASE = 32'h0001_0000,
    parameter int unsigned SCREEN_W  = 320,
    parameter int unsigned SCREEN_H  = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [29:0] address_a,
    input  logic [31:0] data_a,
    input  logic [3:0]  byteena_a,
    input  logic        wren_a,
    output logic [31:0] q_a,
    output logic [29:0] vram_addr,
    output logic [31:0] vram_data,
    output logic [3:0]  vram_byteen,
    output logic        vram_wren,
    input  logic        vram_ready,
    output logic        busy,
    output logic        irq
);

    localparam logic [31:0] SW32 = 32'(SCREEN_W);
    localparam logic [31:0] SH32 = 32'(SCREEN_H);

    localparam logic [2:0] REG_CTRL  = 3'd0;
    localparam logic [2:0] REG_X     = 3'd1;
    localparam logic [2:0] REG_Y     = 3'd2;
    localparam logic [2:0] REG_W     = 3'd3;
    localparam logic [2:0] REG_H     = 3'd4;
    localparam logic [2:0] REG_COLOR = 3'd5;
    localparam logic [2:0] REG_COUNT = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLIP = 2'd1,
        ST_FILL = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Merge a CPU write into an existing register image, lane by lane.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Lane enables for one VRAM word: a lane is on when its byte lies in
    // [first, last]. Byte offset 0 maps to lane 3.
    function automatic logic [3:0] lane_mask(input logic [29:0] word,
                                             input logic [31:0] first,
                                             input logic [31:0] last);
        logic [3:0]  mask;
        logic [31:0] byte_addr;
        mask = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            byte_addr   = {word, 2'(b)};
            mask[3 - b] = (byte_addr >= first) && (byte_addr <= last);
        end
        return mask;
    endfunction

    state_t      state_q, state_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [8:0]  w_q, w_d;
    logic [7:0]  h_q, h_d;
    logic [7:0]  color_q, color_d;
    logic [16:0] count_q, count_d;
    logic [31:0] q_a_q, q_a_d;
    logic [29:0] vram_addr_q, vram_addr_d;
    logic [31:0] vram_data_q, vram_data_d;
    logic [3:0]  vram_byteen_q, vram_byteen_d;
    logic        vram_wren_q, vram_wren_d;
    logic        busy_q, busy_d;
    logic        irq_q, irq_d;
    // Byte address of the first pixel of the row being filled.
    logic [31:0] row_first_q, row_first_d;
    logic [8:0]  eff_w_q, eff_w_d;
    logic [7:0]  rows_left_q, rows_left_d;

    logic        wr_s;
    logic [2:0]  reg_idx_s;
    logic        idle_s;
    logic        ctrl_wr_s;
    logic        go_s;
    logic        done_clr_s;
    logic [31:0] rd_val_s;
    logic [31:0] wr_word_s;
    logic [31:0] rem_w_s;
    logic [31:0] rem_h_s;
    logic [8:0]  clip_w_s;
    logic [7:0]  clip_h_s;
    logic        clip_empty_s;
    logic [31:0] start_s;
    logic [31:0] row_last_s;
    logic [31:0] next_first_s;
    logic [31:0] next_last_s;
    logic [29:0] addr_inc_s;
    logic        unused_bits_s;

    assign wr_s       = sel & wren_a;
    assign reg_idx_s  = address_a[2:0];
    assign idle_s     = (state_q == ST_IDLE);
    assign ctrl_wr_s  = wr_s & (reg_idx_s == REG_CTRL) & byteena_a[0];
    assign go_s       = ctrl_wr_s & data_a[0] & idle_s;
    assign done_clr_s = ctrl_wr_s & data_a[2];
    assign wr_word_s  = merge_lanes(rd_val_s, data_a, byteena_a);

    // Clipping against the right and bottom screen edges.
    assign rem_w_s      = SW32 - {23'd0, x_q};
    assign rem_h_s      = SH32 - {24'd0, y_q};
    assign clip_w_s     = ({23'd0, w_q} < rem_w_s) ? w_q : rem_w_s[8:0];
    assign clip_h_s     = ({24'd0, h_q} < rem_h_s) ? h_q : rem_h_s[7:0];
    assign clip_empty_s = (w_q == 9'd0) || (h_q == 8'd0) ||
                          ({23'd0, x_q} >= SW32) || ({24'd0, y_q} >= SH32);
    assign start_s      = VRAM_BASE + ({24'd0, y_q} * SW32) + {23'd0, x_q};

    // Span bounds of the current row and of the row below it.
    assign row_last_s   = row_first_q + {23'd0, eff_w_q} - 32'd1;
    assign next_first_s = row_first_q + SW32;
    assign next_last_s  = next_first_s + {23'd0, eff_w_q} - 32'd1;
    assign addr_inc_s   = vram_addr_q + 30'd1;

    assign unused_bits_s = ^{address_a[29:3], wr_word_s[31:17]};

    // Read mux: current register image for the addressed register.
    always_comb begin
        rd_val_s = 32'd0;
        case (reg_idx_s)
            REG_CTRL:  rd_val_s = {29'd0, done_q, irq_en_q, busy_q};
            REG_X:     rd_val_s = {23'd0, x_q};
            REG_Y:     rd_val_s = {24'd0, y_q};
            REG_W:     rd_val_s = {23'd0, w_q};
            REG_H:     rd_val_s = {24'd0, h_q};
            REG_COLOR: rd_val_s = {24'd0, color_q};
            REG_COUNT: rd_val_s = {15'd0, count_q};
            default:   rd_val_s = 32'd0;
        endcase
    end

    // Registered read data: captured on any sel cycle, held otherwise.
    always_comb begin
        q_a_d = q_a_q;
        if (sel) begin
            q_a_d = rd_val_s;
        end else begin
            q_a_d = q_a_q;
        end
    end

    // Programmable registers; geometry and colour are frozen while busy.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        color_d  = color_q;
        irq_en_d = irq_en_q;
        if (ctrl_wr_s) begin
            irq_en_d = data_a[1];
        end else begin
            irq_en_d = irq_en_q;
        end
        if (wr_s && idle_s) begin
            case (reg_idx_s)
                REG_X:     x_d     = wr_word_s[8:0];
                REG_Y:     y_d     = wr_word_s[7:0];
                REG_W:     w_d     = wr_word_s[8:0];
                REG_H:     h_d     = wr_word_s[7:0];
                REG_COLOR: color_d = wr_word_s[7:0];
                default:   x_d     = x_q;
            endcase
        end else begin
            x_d = x_q;
        end
    end

    // Fill FSM: next state, VRAM request generation, COUNT and DONE.
    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        count_d       = count_q;
        row_first_d   = row_first_q;
        eff_w_d       = eff_w_q;
        rows_left_d   = rows_left_q;
        vram_addr_d   = vram_addr_q;
        vram_data_d   = vram_data_q;
        vram_byteen_d = vram_byteen_q;
        vram_wren_d   = vram_wren_q;

        if (done_clr_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (go_s) begin
                    state_d = ST_CLIP;
                    done_d  = 1'b0;
                    count_d = 17'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLIP: begin
                if (clip_empty_s) begin
                    state_d = ST_FIN;
                end else begin
                    eff_w_d     = clip_w_s;
                    rows_left_d = clip_h_s;
                    row_first_d = start_s;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!vram_wren_q) begin
                    // First cycle of FILL: present the first word of row 0.
                    vram_addr_d   = row_first_q[31:2];
                    vram_byteen_d = lane_mask(row_first_q[31:2], row_first_q, row_last_s);
                    vram_data_d   = {4{color_q}};
                    vram_wren_d   = 1'b1;
                end else if (vram_ready) begin
                    if (count_q != 17'h1FFFF) begin
                        count_d = count_q + 17'd1;
                    end else begin
                        count_d = count_q;
                    end
                    if (vram_addr_q == row_last_s[31:2]) begin
                        if (rows_left_q == 8'd1) begin
                            state_d       = ST_FIN;
                            vram_wren_d   = 1'b0;
                            vram_addr_d   = 30'd0;
                            vram_data_d   = 32'd0;
                            vram_byteen_d = 4'b0000;
                        end else begin
                            rows_left_d   = rows_left_q - 8'd1;
                            row_first_d   = next_first_s;
                            vram_addr_d   = next_first_s[31:2];
                            vram_byteen_d = lane_mask(next_first_s[31:2], next_first_s, next_last_s);
                        end
                    end else begin
                        vram_addr_d   = addr_inc_s;
                        vram_byteen_d = lane_mask(addr_inc_s, row_first_q, row_last_s);
                    end
                end else begin
                    // Stalled: hold the request exactly as presented.
                    vram_wren_d = 1'b1;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        irq_d  = done_d & irq_en_d;
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            x_q           <= 9'd0;
            y_q           <= 8'd0;
            w_q           <= 9'd0;
            h_q           <= 8'd0;
            color_q       <= 8'd0;
            count_q       <= 17'd0;
            q_a_q         <= 32'd0;
            vram_addr_q   <= 30'd0;
            vram_data_q   <= 32'd0;
            vram_byteen_q <= 4'b0000;
            vram_wren_q   <= 1'b0;
            busy_q        <= 1'b0;
            irq_q         <= 1'b0;
            row_first_q   <= 32'd0;
            eff_w_q       <= 9'd0;
            rows_left_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            x_q           <= x_d;
            y_q           <= y_d;
            w_q           <= w_d;
            h_q           <= h_d;
            color_q       <= color_d;
            count_q       <= count_d;
            q_a_q         <= q_a_d;
            vram_addr_q   <= vram_addr_d;
            vram_data_q   <= vram_data_d;
            vram_byteen_q <= vram_byteen_d;
            vram_wren_q   <= vram_wren_d;
            busy_q        <= busy_d;
            irq_q         <= irq_d;
            row_first_q   <= row_first_d;
            eff_w_q       <= eff_w_d;
            rows_left_q   <= rows_left_d;
        end
    end

    assign q_a         = q_a_q;
    assign vram_addr   = vram_addr_q;
    assign vram_data   = vram_data_q;
    assign vram_byteen = vram_byteen_q;
    assign vram_wren   = vram_wren_q;
    assign busy        = busy_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_vram_fill_responder.sv
`timescale 1ns/1ps
module tb_vram_fill_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int SW = 320;
    localparam int SH = 240;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic [29:0] address_a = 30'd0;
    logic [31:0] data_a = 32'd0;
    logic [3:0]  byteena_a = 4'd0;
    logic        wren_a = 1'b0;
    logic [31:0] q_a;
    logic [29:0] vram_addr;
    logic [31:0] vram_data;
    logic [3:0]  vram_byteen;
    logic        vram_wren;
    logic        vram_ready = 1'b1;
    logic        busy;
    logic        irq;

    vram_fill_responder dut (
        .clk(clk), .reset(reset), .sel(sel), .address_a(address_a),
        .data_a(data_a), .byteena_a(byteena_a), .wren_a(wren_a), .q_a(q_a),
        .vram_addr(vram_addr), .vram_data(vram_data), .vram_byteen(vram_byteen),
        .vram_wren(vram_wren), .vram_ready(vram_ready), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    int  checks = 0;
    int  failures = 0;
    int  model_count = 0;
    bit  chk_en = 1'b0;
    bit  held_valid = 1'b0;
    wr_t held;
    wr_t exp_q[$];
    wr_t act_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Compare every VRAM transaction against the model queue; verify stalls hold.
    always @(negedge clk) begin
        if (chk_en) begin
            if (vram_wren) begin
                if (held_valid) begin
                    check("hold_addr", {2'b00, vram_addr}, {2'b00, held.addr});
                    check("hold_data", vram_data, held.data);
                    check("hold_be", {28'd0, vram_byteen}, {28'd0, held.be});
                end
                if (vram_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual_addr=%h expected=none", vram_addr);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", {2'b00, vram_addr}, {2'b00, e.addr});
                        check("wr_data", vram_data, e.data);
                        check("wr_be", {28'd0, vram_byteen}, {28'd0, e.be});
                    end
                    act_log.push_back('{vram_addr, vram_data, vram_byteen});
                    held_valid = 1'b0;
                end else begin
                    held       = '{vram_addr, vram_data, vram_byteen};
                    held_valid = 1'b1;
                end
            end else begin
                if (held_valid) begin
                    checks++;
                    failures++;
                    $display("FAIL wren_dropped actual=0 expected=1");
                end
                held_valid = 1'b0;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        sel = 1'b1; wren_a = 1'b1; address_a = {27'd0, a}; data_a = d; byteena_a = be;
        step();
        sel = 1'b0; wren_a = 1'b0; byteena_a = 4'd0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; wren_a = 1'b0; address_a = {27'd0, a};
        step();
        sel = 1'b0;
        d = q_a;
    endtask

    // Expected writes, built pixel by pixel: consecutive pixels sharing a
    // word address merge into one write.
    task automatic build_expected(input int x, input int y, input int w, input int h,
                                  input logic [7:0] color);
        int  ew;
        int  eh;
        bit  have;
        wr_t cur;
        exp_q.delete();
        act_log.delete();
        model_count = 0;
        cur = '0;
        if (w == 0 || h == 0 || x >= SW || y >= SH) return;
        ew = (w < SW - x) ? w : SW - x;
        eh = (h < SH - y) ? h : SH - y;
        for (int r = 0; r < eh; r++) begin
            have = 1'b0;
            for (int c = 0; c < ew; c++) begin
                logic [31:0] p;
                p = BASE + 32'((y + r) * SW + x + c);
                if (have && cur.addr != p[31:2]) begin
                    exp_q.push_back(cur);
                    have = 1'b0;
                end
                if (!have) begin
                    cur.addr = p[31:2];
                    cur.data = {4{color}};
                    cur.be   = 4'b0000;
                    have     = 1'b1;
                end
                cur.be[3 - int'(p[1:0])] = 1'b1;
            end
            if (have) exp_q.push_back(cur);
        end
        model_count = (exp_q.size() > 131071) ? 131071 : exp_q.size();
    endtask

    task automatic setup_fill(input int x, input int y, input int w, input int h,
                              input logic [7:0] color);
        bus_write(3'd1, 32'(x), 4'hF);
        bus_write(3'd2, 32'(y), 4'hF);
        bus_write(3'd3, 32'(w), 4'hF);
        bus_write(3'd4, 32'(h), 4'hF);
        bus_write(3'd5, {24'd0, color}, 4'hF);
        build_expected(x, y, w, h, color);
    endtask

    task automatic wait_wren(output int n);
        n = 0;
        while (!vram_wren && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic finish_fill(input string tag, input logic irq_en_exp);
        int n;
        logic [31:0] d;
        n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        bus_read(3'd6, d);
        check({tag, "_count"}, d, 32'(model_count));
        bus_read(3'd0, d);
        check({tag, "_ctrl"}, d, {29'd0, 1'b1, irq_en_exp, 1'b0});
    endtask

    initial begin
        int n;
        logic [31:0] d;

        // Reset while the bus is being hammered with random traffic.
        for (int i = 0; i < 8; i++) begin
            sel = 1'($urandom_range(0, 1)); wren_a = 1'($urandom_range(0, 1));
            address_a = 30'($urandom); data_a = $urandom; byteena_a = 4'($urandom);
            step();
            check("rst_q_a", q_a, 32'd0);
            check("rst_vaddr", {2'b00, vram_addr}, 32'd0);
            check("rst_vdata", vram_data, 32'd0);
            check("rst_flags", {25'd0, vram_byteen, vram_wren, busy, irq}, 32'd0);
        end
        sel = 1'b0; wren_a = 1'b0; byteena_a = 4'd0;
        reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            bus_read(3'(r), d);
            check("rst_reg", d, 32'd0);
        end
        chk_en = 1'b1;

        // Lane-granular register writes; reserved / read-only registers.
        bus_write(3'd1, 32'h0000_0100, 4'b0010);
        bus_read(3'd1, d);  check("x_lane1", d, 32'h0000_0100);
        bus_write(3'd1, 32'hFFFF_FF05, 4'b0001);
        bus_read(3'd1, d);  check("x_lane0", d, 32'h0000_0105);
        bus_write(3'd7, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd7, d);  check("reg7", d, 32'd0);
        bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd6, d);  check("count_ro", d, 32'd0);
        bus_write(3'd0, 32'h0000_0002, 4'h1);
        bus_read(3'd0, d);  check("irq_en_rw", d, 32'h0000_0002);
        bus_write(3'd0, 32'h0000_0000, 4'h1);

        // Single aligned word; first request two cycles after GO.
        setup_fill(0, 0, 4, 1, 8'h5A);
        bus_write(3'd0, 32'h1, 4'h1);
        wait_wren(n);
        check("go_latency", 32'(n), 32'd2);
        finish_fill("fill4", 1'b0);
        check("fill4_n", 32'(act_log.size()), 32'd1);
        if (act_log.size() >= 1) begin
            check("fill4_addr", {2'b00, act_log[0].addr}, 32'h0000_4000);
            check("fill4_data", act_log[0].data, 32'h5A5A_5A5A);
            check("fill4_be", {28'd0, act_log[0].be}, 32'h0000_000F);
        end

        // Unaligned span across two words.
        setup_fill(1, 0, 6, 1, 8'hC3);
        bus_write(3'd0, 32'h1, 4'h1);
        finish_fill("span6", 1'b0);
        check("span6_n", 32'(act_log.size()), 32'd2);
        if (act_log.size() >= 2) begin
            check("span6_a0", {2'b00, act_log[0].addr}, 32'h0000_4000);
            check("span6_b0", {28'd0, act_log[0].be}, 32'h0000_0007);
            check("span6_a1", {2'b00, act_log[1].addr}, 32'h0000_4001);
            check("span6_b1", {28'd0, act_log[1].be}, 32'h0000_000E);
        end

        // Bottom-right corner clip; GO together with DONE-clear.
        setup_fill(318, 239, 10, 5, 8'h11);
        bus_write(3'd0, 32'h5, 4'h1);
        bus_read(3'd0, d);
        check("go_clr_ctrl", d, 32'h0000_0001);
        finish_fill("corner", 1'b0);
        check("corner_n", 32'(act_log.size()), 32'd1);
        if (act_log.size() >= 1) begin
            check("corner_addr", {2'b00, act_log[0].addr}, 32'h0000_8AFF);
            check("corner_be", {28'd0, act_log[0].be}, 32'h0000_0003);
        end

        // Back-pressure mid-fill; COLOR write during busy is ignored.
        setup_fill(0, 1, 16, 2, 8'h77);
        bus_write(3'd0, 32'h1, 4'h1);
        wait_wren(n);
        step();
        vram_ready = 1'b0;
        bus_write(3'd5, 32'h0000_00EE, 4'hF);
        step();
        step();
        vram_ready = 1'b1;
        finish_fill("stall", 1'b0);
        check("stall_n", 32'(act_log.size()), 32'd8);
        bus_read(3'd5, d);
        check("color_locked", d, 32'h0000_0077);

        // Empty rectangle with interrupt enabled, then clear DONE.
        setup_fill(5, 5, 0, 3, 8'h01);
        bus_write(3'd0, 32'h3, 4'h1);
        n = 0;
        while (!irq && n < 3) begin
            step();
            n++;
        end
        check("empty_irq", {31'd0, irq}, 32'd1);
        finish_fill("empty", 1'b1);
        bus_write(3'd0, 32'h6, 4'h1);
        check("irq_clear", {31'd0, irq}, 32'd0);

        // Reset in the middle of a long fill.
        setup_fill(0, 0, 100, 10, 8'hAB);
        bus_write(3'd0, 32'h1, 4'h1);
        wait_wren(n);
        step();
        step();
        reset = 1'b1;
        chk_en = 1'b0;
        step();
        check("midrst_wren", {31'd0, vram_wren}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (vram_wren) n++;
        end
        check("midrst_quiet", 32'(n), 32'd0);
        bus_read(3'd0, d);
        check("midrst_ctrl", d, 32'd0);
        chk_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
